// File: rtl/sdram_ctrl.sv
// Closed-page SDR SDRAM controller: 32-bit word requests become two-beat (BL=2, CL=2)
// ACTIVE/READ|WRITE/PRECHARGE sequences, with power-up init and periodic auto-refresh.
module sdram_ctrl #(
  parameter int unsigned INIT_WAIT      = 200,
  parameter int unsigned TRP            = 2,
  parameter int unsigned TRCD           = 2,
  parameter int unsigned TRFC           = 7,
  parameter int unsigned REFRESH_CYCLES = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        sdram_cke,
  output logic        sdram_cs,
  output logic        sdram_ras,
  output logic        sdram_cas,
  output logic        sdram_we,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [1:0]  sdram_dqm,
  inout  wire  [15:0] sdram_dq
);

  localparam int unsigned MAX_A    = (TRP > TRCD) ? TRP : TRCD;
  localparam int unsigned MAX_B    = (TRFC > INIT_WAIT) ? TRFC : INIT_WAIT;
  localparam int unsigned MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int unsigned REF_W    = $clog2(REFRESH_CYCLES);

  // {cs, ras, cas, we}
  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [3:0] {
    INIT_WAIT_S, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, RW_CMD,
    WR_BEAT1, RD_WAIT, RD_BEAT0, RD_BEAT1, PRE, REF_PRE, REF, RESP
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [REF_W-1:0]   ref_cnt, ref_cnt_n;
  logic               ref_pend, ref_pend_n, ref_wrap, ref_done;
  logic [3:0]         cmd_q, cmd_n;
  logic [12:0]        a_n;
  logic [1:0]         ba_n, dqm_n;
  logic               dq_oe, dq_oe_n;
  logic [15:0]        dq_out, dq_out_n, rd_lo;
  logic               req_ready_n, resp_valid_n, accept, wait_done;
  logic               wen_q;
  logic [8:0]         col_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               unused_addr;

  assign unused_addr = ^{req_addr[31:25], req_addr[1:0]};
  assign sdram_cke   = 1'b1;
  assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd_q;
  assign sdram_dq    = dq_oe ? dq_out : 16'hzzzz;

  // Next-state and next-pin decode; pins are registered so each state's command
  // is on the bus for the first cycle spent in that state.
  always_comb begin
    state_n      = state;
    cnt_n        = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    cmd_n        = CMD_NOP;
    a_n          = sdram_a;
    ba_n         = sdram_ba;
    dqm_n        = 2'b11;
    dq_oe_n      = 1'b0;
    dq_out_n     = dq_out;
    resp_valid_n = 1'b0;
    ref_done     = 1'b0;
    accept       = 1'b0;
    wait_done    = (cnt == '0);
    ref_wrap     = (ref_cnt == REF_W'(REFRESH_CYCLES - 1));
    ref_cnt_n    = ref_wrap ? '0 : ref_cnt + REF_W'(1);
    case (state)
      INIT_WAIT_S: if (wait_done) begin
        state_n = INIT_PRE; cmd_n = CMD_PRE; a_n = 13'h0400; cnt_n = CNT_W'(TRP);
      end
      INIT_PRE: if (wait_done) begin
        state_n = INIT_REF1; cmd_n = CMD_REF; cnt_n = CNT_W'(TRFC);
      end
      INIT_REF1: if (wait_done) begin
        state_n = INIT_REF2; cmd_n = CMD_REF; cnt_n = CNT_W'(TRFC);
      end
      INIT_REF2: if (wait_done) begin
        state_n = INIT_MRS; cmd_n = CMD_MRS; a_n = 13'h021; ba_n = 2'b00; cnt_n = CNT_W'(2);
      end
      INIT_MRS: if (wait_done) state_n = IDLE;
      IDLE: begin
        if (ref_pend) begin
          state_n = REF_PRE; cmd_n = CMD_PRE; a_n = 13'h0400; cnt_n = CNT_W'(TRP);
        end else if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_n = ACT; cmd_n = CMD_ACT;
          ba_n    = req_addr[11:10]; a_n = req_addr[24:12]; cnt_n = CNT_W'(TRCD);
        end
      end
      ACT: if (wait_done) begin
        state_n = RW_CMD;
        a_n     = {4'b0000, col_q};
        if (wen_q) begin
          cmd_n = CMD_WR; dq_oe_n = 1'b1; dq_out_n = wdata_q[15:0]; dqm_n = ~wstrb_q[1:0];
        end else begin
          cmd_n = CMD_RD; dqm_n = 2'b00;
        end
      end
      RW_CMD: begin
        if (wen_q) begin
          state_n = WR_BEAT1; dq_oe_n = 1'b1; dq_out_n = wdata_q[31:16]; dqm_n = ~wstrb_q[3:2];
        end else begin
          state_n = RD_WAIT; dqm_n = 2'b00;
        end
      end
      WR_BEAT1: begin state_n = RESP; resp_valid_n = 1'b1; end
      RD_WAIT:  begin state_n = RD_BEAT0; dqm_n = 2'b00; end
      RD_BEAT0: begin state_n = RD_BEAT1; dqm_n = 2'b00; end
      RD_BEAT1: begin state_n = RESP; resp_valid_n = 1'b1; end
      RESP: begin
        state_n = PRE; cmd_n = CMD_PRE; a_n = 13'h0000; cnt_n = CNT_W'(TRP);
      end
      PRE: if (wait_done) state_n = IDLE;
      REF_PRE: if (wait_done) begin
        state_n = REF; cmd_n = CMD_REF; cnt_n = CNT_W'(TRFC);
      end
      REF: if (wait_done) begin state_n = IDLE; ref_done = 1'b1; end
      default: state_n = INIT_WAIT_S;
    endcase
    // A wrap while already pending collapses into the one outstanding refresh.
    ref_pend_n  = ref_wrap | (ref_pend & ~ref_done);
    req_ready_n = (state_n == IDLE) && !ref_pend_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_WAIT_S;
      cnt        <= CNT_W'(INIT_WAIT);
      ref_cnt    <= '0;
      ref_pend   <= 1'b0;
      cmd_q      <= CMD_INH;
      sdram_a    <= '0;
      sdram_ba   <= '0;
      sdram_dqm  <= 2'b11;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      rd_lo      <= '0;
      wen_q      <= 1'b0;
      col_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ref_cnt    <= ref_cnt_n;
      ref_pend   <= ref_pend_n;
      cmd_q      <= cmd_n;
      sdram_a    <= a_n;
      sdram_ba   <= ba_n;
      sdram_dqm  <= dqm_n;
      dq_oe      <= dq_oe_n;
      dq_out     <= dq_out_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      if (accept) begin
        wen_q   <= req_wen;
        col_q   <= {req_addr[9:2], 1'b0};
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state == RD_BEAT0) rd_lo <= sdram_dq;
      if (state == RD_BEAT1) resp_rdata <= {sdram_dq, rd_lo};
    end
  end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl: a small SDRAM memory model on the pins plus a
// command log, checked with immediate assertions against hand-derived values.
module tb_sdram_ctrl;

  localparam int INIT_WAIT = 200;
  localparam int TRP       = 2;
  localparam int TRCD      = 2;
  localparam int TRFC      = 7;

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  wire         req_ready, resp_valid;
  wire  [31:0] resp_rdata;
  wire         sdram_cke, sdram_cs, sdram_ras, sdram_cas, sdram_we;
  wire  [12:0] sdram_a;
  wire  [1:0]  sdram_ba, sdram_dqm;
  wire  [15:0] sdram_dq;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;

  assign sdram_dq = tb_oe ? tb_dq : 16'hzzzz;

  sdram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sdram_cke(sdram_cke), .sdram_cs(sdram_cs), .sdram_ras(sdram_ras),
    .sdram_cas(sdram_cas), .sdram_we(sdram_we), .sdram_a(sdram_a),
    .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_dq(sdram_dq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [12:0] a;
    logic [1:0]  ba;
    int          cyc;
  } ent_t;

  ent_t        log_q[$];
  logic [15:0] mem [int unsigned];
  logic [12:0] open_row [4];
  int          cyc = 0, resp_cnt = 0, rd_stage = 0;
  int unsigned rd_key = 0, wr_key = 0;
  logic        wr_pend = 1'b0;
  logic [1:0]  wr_dqm0 = 2'b11, wr_dqm1 = 2'b11;
  wire  [3:0]  cmd_w = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
  int          ncmp = 0, nerr = 0;
  logic [3:0]  xc [6] = '{C_ACT, C_RD, C_PRE, C_ACT, C_RD, C_PRE};
  logic [1:0]  xb [6] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};

  function automatic int unsigned mkey(logic [1:0] ba, logic [12:0] row, logic [8:0] col);
    return {8'h00, ba, row, col};
  endfunction

  function automatic int unsigned akey(logic [31:0] addr);
    return mkey(addr[11:10], addr[24:12], {addr[9:2], 1'b0});
  endfunction

  function automatic logic [15:0] rd16(int unsigned k);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  task automatic mem_wr(input int unsigned k, input logic [15:0] d, input logic [1:0] m);
    logic [15:0] v;
    v = rd16(k);
    if (!m[0]) v[7:0]  = d[7:0];
    if (!m[1]) v[15:8] = d[15:8];
    mem[k] = v;
  endtask

  function automatic ent_t ent(int i);
    ent_t d;
    d = '{4'hF, 13'h1FFF, 2'b11, -1000};
    if (i < log_q.size()) d = log_q[i];
    return d;
  endfunction

  // SDRAM device model: CL=2 read drive, two-beat masked write, command log.
  always @(posedge clk) begin
    int unsigned k;
    if (rd_stage == 1) begin tb_oe <= 1'b1; tb_dq <= rd16(rd_key); rd_stage = 2; end
    else if (rd_stage == 2) begin tb_dq <= rd16(rd_key + 1); rd_stage = 3; end
    else if (rd_stage == 3) begin tb_oe <= 1'b0; rd_stage = 0; end
    if (wr_pend) begin mem_wr(wr_key, sdram_dq, sdram_dqm); wr_dqm1 = sdram_dqm; wr_pend = 1'b0; end
    if (!sdram_cs && cmd_w != C_NOP) begin
      log_q.push_back('{cmd_w, sdram_a, sdram_ba, cyc});
      k = mkey(sdram_ba, open_row[sdram_ba], sdram_a[8:0]);
      case (cmd_w)
        C_ACT: open_row[sdram_ba] = sdram_a;
        C_RD:  begin rd_key = k; rd_stage = 1; end
        C_WR:  begin
          mem_wr(k, sdram_dq, sdram_dqm); wr_dqm0 = sdram_dqm; wr_key = k + 1; wr_pend = 1'b1;
        end
        default: ;
      endcase
    end
    if (resp_valid) resp_cnt++;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd);
    int n;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = st;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    chk("accept_in_time", 32'(n < 2000), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("resp_in_time", 32'(n < 50), 32'd1);
    rd = resp_rdata;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, output int at);
    int n;
    n = 0;
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 400), 32'd1);
    at = cyc;
  endtask

  task automatic chk_init(input int rel, input int rdy);
    ent_t e;
    chk("init_cmd_count", 32'(log_q.size()), 32'd4);
    e = ent(0);
    chk("init_pre_cmd", 32'(e.cmd), 32'(C_PRE));
    chk("init_pre_a10", 32'(e.a[10]), 32'd1);
    chk("init_wait_nops", 32'(e.cyc - rel), 32'(INIT_WAIT + 1));
    e = ent(1);
    chk("init_ref1_cmd", 32'(e.cmd), 32'(C_REF));
    chk("init_trp", 32'(e.cyc - ent(0).cyc), 32'(TRP + 1));
    e = ent(2);
    chk("init_ref2_cmd", 32'(e.cmd), 32'(C_REF));
    chk("init_trfc1", 32'(e.cyc - ent(1).cyc), 32'(TRFC + 1));
    e = ent(3);
    chk("init_mrs_cmd", 32'(e.cmd), 32'(C_MRS));
    chk("init_mrs_a", 32'(e.a), 32'h021);
    chk("init_trfc2", 32'(e.cyc - ent(2).cyc), 32'(TRFC + 1));
    chk("init_ready_after_mrs", 32'(rdy - e.cyc), 32'd3);
  endtask

  initial begin
    logic [31:0] rd;
    int rel, rdy, b, n;
    ent_t e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(sdram_cs), 32'd1);
    chk("rst_ras_cas_we", 32'({sdram_ras, sdram_cas, sdram_we}), 32'h7);
    chk("rst_a", 32'(sdram_a), 32'd0);
    chk("rst_ba", 32'(sdram_ba), 32'd0);
    chk("rst_dqm", 32'(sdram_dqm), 32'h3);
    chk("rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("cke", 32'(sdram_cke), 32'd1);

    // Power-up init sequence
    rst = 1'b0; rel = cyc; log_q.delete();
    wait_ready("init_ready_in_time", rdy);
    chk_init(rel, rdy);

    // Full write then read: addr 0x1A04 -> ba=2, row=1, col=0x102
    log_q.delete(); b = resp_cnt;
    do_req(1'b1, 32'h0000_1A04, 32'hDEAD_BEEF, 4'hF, rd);
    e = ent(0);
    chk("wr_act_cmd", 32'(e.cmd), 32'(C_ACT));
    chk("wr_act_ba", 32'(e.ba), 32'd2);
    chk("wr_act_row", 32'(e.a), 32'd1);
    e = ent(1);
    chk("wr_cmd", 32'(e.cmd), 32'(C_WR));
    chk("wr_col", 32'(e.a), 32'h102);
    chk("wr_ba", 32'(e.ba), 32'd2);
    chk("wr_trcd", 32'(e.cyc - ent(0).cyc), 32'(TRCD + 1));
    chk("wr_dqm_beat0", 32'(wr_dqm0), 32'd0);
    chk("wr_dqm_beat1", 32'(wr_dqm1), 32'd0);
    e = ent(2);
    chk("wr_pre_cmd", 32'(e.cmd), 32'(C_PRE));
    chk("wr_pre_ba", 32'(e.ba), 32'd2);
    chk("wr_pre_a10", 32'(e.a[10]), 32'd0);
    chk("wr_resp_pulses", 32'(resp_cnt - b), 32'd1);
    chk("wr_mem_beat0", 32'(rd16(mkey(2'd2, 13'd1, 9'h102))), 32'hBEEF);
    chk("wr_mem_beat1", 32'(rd16(mkey(2'd2, 13'd1, 9'h103))), 32'hDEAD);

    log_q.delete();
    do_req(1'b0, 32'h0000_1A04, 32'h0, 4'h0, rd);
    chk("rd_data_full", rd, 32'hDEAD_BEEF);
    e = ent(1);
    chk("rd_cmd", 32'(e.cmd), 32'(C_RD));
    chk("rd_col", 32'(e.a), 32'h102);
    chk("rd_rdata_held", resp_rdata, 32'hDEAD_BEEF);

    // Partial write: only the low half-word enabled
    do_req(1'b1, 32'h0000_1A04, 32'h1234_5678, 4'b0011, rd);
    chk("pw_dqm_beat0", 32'(wr_dqm0), 32'h0);
    chk("pw_dqm_beat1", 32'(wr_dqm1), 32'h3);
    do_req(1'b0, 32'h0000_1A04, 32'h0, 4'h0, rd);
    chk("pw_rd_data", rd, 32'hDEAD_5678);

    // Refresh pending while idle beats a newly raised request
    log_q.delete();
    n = 0;
    while (req_ready && n < 1000) begin @(negedge clk); n++; end
    chk("ref_pending_seen", 32'(n < 1000), 32'd1);
    b = resp_cnt;
    do_req(1'b0, 32'h0000_1A04, 32'h0, 4'h0, rd);
    chk("ref_rd_data", rd, 32'hDEAD_5678);
    e = ent(0);
    chk("ref_pre_cmd", 32'(e.cmd), 32'(C_PRE));
    chk("ref_pre_a10", 32'(e.a[10]), 32'd1);
    e = ent(1);
    chk("ref_cmd", 32'(e.cmd), 32'(C_REF));
    chk("ref_trp", 32'(e.cyc - ent(0).cyc), 32'(TRP + 1));
    e = ent(2);
    chk("ref_then_act", 32'(e.cmd), 32'(C_ACT));
    chk("ref_ready_after_trfc", 32'(e.cyc - ent(1).cyc), 32'(TRFC + 2));
    chk("ref_resp_pulses", 32'(resp_cnt - b), 32'd1);

    // Back-to-back reads to bank 0 and bank 3
    mem[akey(32'h0000_0000)]     = 16'h1111;
    mem[akey(32'h0000_0000) + 1] = 16'h2222;
    mem[akey(32'h0000_0C08)]     = 16'h3333;
    mem[akey(32'h0000_0C08) + 1] = 16'h4444;
    log_q.delete(); b = resp_cnt;
    do_req(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd);
    chk("b2b_rd0", rd, 32'h2222_1111);
    do_req(1'b0, 32'h0000_0C08, 32'h0, 4'h0, rd);
    chk("b2b_rd3", rd, 32'h4444_3333);
    chk("b2b_cmd_count", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      e = ent(i);
      chk($sformatf("b2b_cmd%0d", i), 32'(e.cmd), 32'(xc[i]));
      chk($sformatf("b2b_ba%0d", i), 32'(e.ba), 32'(xb[i]));
    end
    chk("b2b_col3", 32'(ent(4).a), 32'h004);
    chk("b2b_resp_pulses", 32'(resp_cnt - b), 32'd2);

    // Reset asserted while waiting for read data
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_1A04;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (cmd_w !== C_RD && n < 20) begin @(negedge clk); n++; end
    chk("mid_read_cmd_seen", 32'(n < 20), 32'd1);
    @(negedge clk);
    rst = 1'b1; b = resp_cnt;
    @(negedge clk);
    chk("mid_rst_cs", 32'(sdram_cs), 32'd1);
    chk("mid_rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_dqm", 32'(sdram_dqm), 32'h3);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; rel = cyc; log_q.delete();
    wait_ready("reinit_ready_in_time", rdy);
    chk("mid_rst_no_resp", 32'(resp_cnt - b), 32'd0);
    chk_init(rel, rdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
